// File: rtl/rom_ram_port.sv
// Single-port byte-strobed memory with a valid/ready request channel and a
// credit-bounded, backpressurable response queue (read-first on writes).
module rom_ram_port #(
    parameter int    DATA_WIDTH    = 32,
    parameter int    ADDRESS_WIDTH = 12,
    parameter string FILE          = "mem.txt",
    parameter int    OUT_REG       = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NB);
    localparam int WAW    = ADDRESS_WIDTH - LSB;
    localparam int WORDS  = 2 ** WAW;
    localparam int STAGES = 1 + OUT_REG;
    localparam int DEPTH  = 2 + OUT_REG;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFS_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic           accept;
    logic           rsp_hs;
    logic           misal;
    logic [WAW-1:0] waddr;

    assign misal  = |(req_addr & OFS_MASK);
    assign waddr  = req_addr[ADDRESS_WIDTH-1:LSB];
    assign accept = req_valid && req_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Credits count every response owed, whether still in the pipe or queued.
    logic [CW-1:0] cred_q, cred_d;

    assign req_ready = resetn && (cred_q < CW'(DEPTH));

    always_comb begin
        cred_d = cred_q + CW'(accept) - CW'(rsp_hs);
    end

    logic [STAGES-1:0]                 vld_pipe_q, vld_pipe_d;
    logic [STAGES-1:0][DATA_WIDTH-1:0] pdat_q;
    logic [STAGES-1:0]                 perr_q;
    logic                              tail_vld;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = accept;
        for (int i = 1; i < STAGES; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    assign tail_vld = vld_pipe_q[STAGES-1];

    logic [DATA_WIDTH-1:0] qdat_q [DEPTH];
    logic [DATA_WIDTH-1:0] qdat_d [DEPTH];
    logic [DEPTH-1:0]      qerr_q, qerr_d;
    logic [CW-1:0]         qcnt_q, qcnt_d;
    logic                  q_nonempty;

    assign q_nonempty = (qcnt_q != '0);

    // The pipe never stalls: its tail either leaves directly through the
    // output (queue empty, consumer ready) or parks at the back of the queue.
    always_comb begin
        qdat_d = qdat_q;
        qerr_d = qerr_q;
        qcnt_d = qcnt_q;
        if (q_nonempty && rsp_ready) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                qdat_d[i] = qdat_q[i+1];
                qerr_d[i] = qerr_q[i+1];
            end
            qcnt_d = qcnt_q - CW'(1);
        end
        if (tail_vld && (q_nonempty || !rsp_ready)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == qcnt_d) begin
                    qdat_d[i] = pdat_q[STAGES-1];
                    qerr_d[i] = perr_q[STAGES-1];
                end
            end
            qcnt_d = qcnt_d + CW'(1);
        end
    end

    always_comb begin
        rsp_valid = q_nonempty || tail_vld;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (q_nonempty) begin
            rsp_rdata = qdat_q[0];
            rsp_err   = qerr_q[0];
        end else if (tail_vld) begin
            rsp_rdata = pdat_q[STAGES-1];
            rsp_err   = perr_q[STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cred_q     <= '0;
            vld_pipe_q <= '0;
            qcnt_q     <= '0;
        end else begin
            cred_q     <= cred_d;
            vld_pipe_q <= vld_pipe_d;
            qcnt_q     <= qcnt_d;
        end
    end

    // Payload registers carry no reset; the valid bits above qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            pdat_q[0] <= misal ? '0 : mem_q[waddr];
            perr_q[0] <= misal;
        end
        for (int i = 1; i < STAGES; i++) begin
            pdat_q[i] <= pdat_q[i-1];
            perr_q[i] <= perr_q[i-1];
        end
        qdat_q <= qdat_d;
        qerr_q <= qerr_d;
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !misal) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_ram_port.sv
// Bench for rom_ram_port: two instances (OUT_REG=0 and 1) checked every cycle
// against a transaction-level model of memory contents and owed responses.
module tb_rom_ram_port;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NW = 16;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [NI-1:0]         req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [NI-1:0][AW-1:0] req_addr;
    logic [NI-1:0][DW-1:0] req_wdata, rsp_rdata;
    logic [NI-1:0][3:0]    req_wstrb;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rom_ram_port #(
            .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FILE(""), .OUT_REG(g)
        ) u_dut (
            .clk(clk), .resetn(resetn),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_wstrb(req_wstrb[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            avail;
    } rsp_t;

    rsp_t          mq[NI][$];
    logic [DW-1:0] mmem[NI][NW];
    bit            clean[NI];
    int            cyc, nacc, npass, nfail, ntotal;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responses are owed in acceptance order, each visible from cycle
    // accept+1+OUT_REG until consumed; at most 2+OUT_REG may be owed.
    task automatic model_edge();
        for (int u = 0; u < NI; u++) begin
            bit   hs, acc, mis;
            int   wa;
            rsp_t r;
            if (!resetn) begin
                mq[u].delete();
                clean[u] = 1'b1;
            end else begin
                hs  = mq[u].size() > 0 && mq[u][0].avail <= cyc && rsp_ready[u];
                acc = req_valid[u] && mq[u].size() < 2 + u;
                if (hs) void'(mq[u].pop_front());
                if (acc) begin
                    wa      = int'(req_addr[u]) / 4;
                    mis     = (int'(req_addr[u]) % 4) != 0;
                    r.err   = mis;
                    r.data  = mis ? '0 : mmem[u][wa];
                    r.avail = cyc + 1 + u;
                    if (!mis && req_we[u])
                        for (int b = 0; b < 4; b++)
                            if (req_wstrb[u][b]) mmem[u][wa][8*b +: 8] = req_wdata[u][8*b +: 8];
                    mq[u].push_back(r);
                    nacc++;
                end
            end
        end
        cyc++;
    endtask

    task automatic model_check();
        for (int u = 0; u < NI; u++) begin
            bit ev;
            ev = mq[u].size() > 0 && mq[u][0].avail <= cyc;
            chk($sformatf("req_ready[%0d]", u), req_ready[u], resetn && mq[u].size() < 2 + u);
            chk($sformatf("rsp_valid[%0d]", u), rsp_valid[u], ev);
            if (ev) begin
                clean[u] = 1'b0;
                if (!$isunknown(mq[u][0].data))
                    chk($sformatf("rsp_rdata[%0d]", u), rsp_rdata[u], mq[u][0].data);
                chk($sformatf("rsp_err[%0d]", u), rsp_err[u], mq[u][0].err);
            end else if (clean[u]) begin
                chk($sformatf("idle_rdata[%0d]", u), rsp_rdata[u], '0);
                chk($sformatf("idle_err[%0d]", u), rsp_err[u], '0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(int u);
        req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
        req_wdata[u] = '0;   req_wstrb[u] = '0;
    endtask

    task automatic rd(int u, logic [AW-1:0] a);
        req_valid[u] = 1'b1; req_we[u] = 1'b0; req_addr[u] = a;
        req_wdata[u] = '0;   req_wstrb[u] = '0;
    endtask

    task automatic wr(int u, logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] s);
        req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = a;
        req_wdata[u] = d;    req_wstrb[u] = s;
    endtask

    initial begin
        int n, c;
        logic [DW-1:0] v;
        cyc = 0; nacc = 0; npass = 0; nfail = 0; ntotal = 0;
        for (int u = 0; u < NI; u++) begin
            for (int w = 0; w < NW; w++) mmem[u][w] = 'x;
            idle(u);
        end
        resetn    = 1'b0;
        rsp_ready = '1;
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Stand-in for the hex image: word0/word1 fixed, the rest random.
        for (int w = 0; w < NW; w++) begin
            v = (w == 0) ? 32'h11223344 : (w == 1) ? 32'hAABBCCDD : $urandom;
            for (int u = 0; u < NI; u++) wr(u, AW'(w * 4), v, 4'hF);
            tick();
        end
        idle(0); idle(1);
        tick(); tick(); tick();

        // Back-to-back reads, OUT_REG=0
        rd(0, 6'h0); tick();
        chk("t1_valid0", rsp_valid[0], 1'b1);
        chk("t1_data0", rsp_rdata[0], 32'h11223344);
        rd(0, 6'h4); tick();
        chk("t1_data1", rsp_rdata[0], 32'hAABBCCDD);
        chk("t1_err1", rsp_err[0], 1'b0);
        idle(0); tick();

        // Strobed write returns the old word; the read returns the merge.
        wr(0, 6'h4, 32'h55667788, 4'b0101); tick();
        chk("t2_wr_old", rsp_rdata[0], 32'hAABBCCDD);
        rd(0, 6'h4); tick();
        chk("t2_rd_new", rsp_rdata[0], 32'hAA66CC88);

        // Misaligned read
        rd(0, 6'h6); tick();
        chk("t3_mis_err", rsp_err[0], 1'b1);
        chk("t3_mis_data", rsp_rdata[0], 32'h0);
        rd(0, 6'h4); tick();
        chk("t3_unchanged", rsp_rdata[0], 32'hAA66CC88);
        idle(0); tick();

        // Backpressure, OUT_REG=1: three accepted, then stall.
        rsp_ready[1] = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            rd(1, AW'(i * 4));
            if (req_ready[1]) n++;
            tick();
        end
        chk("t4_accepted", n, 3);
        chk("t4_ready_low", req_ready[1], 1'b0);
        tick(); tick();
        rsp_ready[1] = 1'b1;
        rd(1, 6'hC); tick();
        rd(1, 6'h10);
        for (int i = 0; i < 4; i++) tick();
        idle(1);
        for (int i = 0; i < 4; i++) tick();

        // Reset with buffered responses outstanding.
        rsp_ready[1] = 1'b0;
        wr(1, 6'h8, 32'hDEADBEEF, 4'hF); tick();
        rd(1, 6'h0); tick();
        rd(1, 6'h4); tick();
        idle(1); tick();
        resetn = 1'b0; tick();
        chk("t5_rst_valid", rsp_valid[1], 1'b0);
        chk("t5_rst_data", rsp_rdata[1], 32'h0);
        chk("t5_rst_err", rsp_err[1], 1'b0);
        chk("t5_rst_ready", req_ready[1], 1'b0);
        resetn = 1'b1; rsp_ready[1] = 1'b1; tick(); tick();
        chk("t5_no_stale", rsp_valid[1], 1'b0);
        rd(1, 6'h8); tick();
        idle(1); tick();
        chk("t5_committed", rsp_rdata[1], 32'hDEADBEEF);
        tick(); tick();

        // Random traffic with random consumer stalls.
        nacc = 0;
        c = 0;
        while (nacc < 10000 && c < 40000) begin
            for (int u = 0; u < NI; u++) begin
                if ($urandom_range(9) < 7) begin
                    if ($urandom_range(4) != 0) req_addr[u] = AW'($urandom_range(NW - 1) * 4);
                    else req_addr[u] = AW'($urandom);
                    req_valid[u] = 1'b1;
                    req_we[u]    = 1'($urandom);
                    req_wdata[u] = $urandom;
                    req_wstrb[u] = 4'($urandom);
                end else begin
                    idle(u);
                end
                rsp_ready[u] = ($urandom_range(9) < 6);
            end
            tick();
            c++;
        end
        chk("rand_completed", nacc >= 10000, 1'b1);
        idle(0); idle(1);
        rsp_ready = '1;
        for (int i = 0; i < 6; i++) tick();
        chk("drained0", rsp_valid[0], 1'b0);
        chk("drained1", rsp_valid[1], 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
